// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin arbiter sharing one clocked 32.32 multiplier across NR requesters
module mult_share_arb #(
  parameter int NR = 4,
  parameter int DW = 64,
  parameter int TMO = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NR-1:0]    req_i,
  input  logic [NR*DW-1:0] a_i,
  input  logic [NR*DW-1:0] b_i,
  output logic [NR-1:0]    gnt_o,
  output logic [NR-1:0]    done_o,
  output logic             err_o,
  output logic [DW-1:0]    c_o,
  output logic             busy_o,
  output logic             m_en_o,
  output logic [DW-1:0]    m_a_o,
  output logic [DW-1:0]    m_b_o,
  input  logic             m_valid_i,
  input  logic [DW-1:0]    m_c_i
);
  localparam int PW = $clog2(NR);
  localparam int TW = $clog2(TMO);
  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;
  state_t          st;
  logic [PW-1:0]   ptr, own, win;
  logic [TW-1:0]   tmo_cnt;
  always_comb begin
    win = '0;
    for (int k = NR - 1; k >= 0; k--)
      win = req_i[(int'(ptr) + k) % NR] ? PW'((int'(ptr) + k) % NR) : win;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st      <= IDLE;
      ptr     <= '0;
      own     <= '0;
      tmo_cnt <= '0;
      gnt_o   <= '0;
      done_o  <= '0;
      err_o   <= 1'b0;
      c_o     <= '0;
      busy_o  <= 1'b0;
      m_en_o  <= 1'b0;
      m_a_o   <= '0;
      m_b_o   <= '0;
    end else begin
      case (st)
        IDLE: if (|req_i) begin
          own     <= win;
          gnt_o   <= NR'(1) << win;
          m_a_o   <= a_i[int'(win)*DW +: DW];
          m_b_o   <= b_i[int'(win)*DW +: DW];
          m_en_o  <= 1'b1;
          busy_o  <= 1'b1;
          tmo_cnt <= '0;
          st      <= WAIT;
        end
        WAIT: begin
          m_en_o <= 1'b0;
          if (m_valid_i || tmo_cnt == TW'(TMO - 1)) begin
            c_o    <= m_valid_i ? m_c_i : '0;
            done_o <= gnt_o;
            err_o  <= !m_valid_i;
            st     <= RELEASE;
          end else
            tmo_cnt <= tmo_cnt + 1'b1;
        end
        RELEASE: begin
          done_o <= '0;
          err_o  <= 1'b0;
          gnt_o  <= '0;
          busy_o <= 1'b0;
          ptr    <= own == PW'(NR - 1) ? '0 : own + 1'b1;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: table, directed and random checks of mult_share_arb against a reference model
module tb_mult_share_arb;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int TMO = 8;
  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req_i = '0;
  logic [NR*DW-1:0] a_i = '0;
  logic [NR*DW-1:0] b_i = '0;
  logic [NR-1:0]    gnt_o, done_o;
  logic             err_o, busy_o, m_en_o;
  logic [DW-1:0]    c_o, m_a_o, m_b_o;
  logic             m_valid_i = 1'b0;
  logic [DW-1:0]    m_c_i = '0;
  mult_share_arb #(.NR(NR), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .c_o(c_o), .busy_o(busy_o),
    .m_en_o(m_en_o), .m_a_o(m_a_o), .m_b_o(m_b_o), .m_valid_i(m_valid_i), .m_c_i(m_c_i)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0, lat = 3, cnt = 0, mptr = 0, cyc = 0;
  bit never = 1'b0, pend = 1'b0;
  logic [DW-1:0] ma, mb;
  typedef struct {
    logic [NR-1:0] req;
    int            lat;
    logic [DW-1:0] a, b, c;
    int            w;
  } vec_t;
  vec_t tv[6];
  function automatic logic [DW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    return p[DW+31:32];
  endfunction
  function automatic int pick(input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++)
      if (r[(mptr + k) % NR]) return (mptr + k) % NR;
    return -1;
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    m_valid_i = 1'b0;
    if (m_en_o && rstn) begin
      pend = 1'b1;
      cnt = lat;
      ma = m_a_o;
      mb = m_b_o;
    end
    if (never) pend = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        m_valid_i = 1'b1;
        m_c_i = mul(ma, mb);
        pend = 1'b0;
      end
    end
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (done_o == '0 && n < 100);
  endtask
  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      a_i[i*DW +: DW] = {$urandom(), $urandom()};
      b_i[i*DW +: DW] = {$urandom(), $urandom()};
    end
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_gnt"}, gnt_o, 0);
    chk({name, "_done"}, done_o, 0);
    chk({name, "_err"}, err_o, 0);
    chk({name, "_c"}, c_o, 0);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_men"}, m_en_o, 0);
    chk({name, "_ma"}, m_a_o, 0);
    chk({name, "_mb"}, m_b_o, 0);
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    req_i = '0;
    step();
    step();
    chk_zero("rst");
    rstn = 1'b1;
    mptr = 0;
  endtask
  task automatic run_op(input logic [NR-1:0] req, input int l, input int w,
                        input logic [DW-1:0] c, input bit exp_err);
    logic [DW-1:0] ea, eb;
    int n;
    req_i = req;
    lat = l;
    ea = a_i[w*DW +: DW];
    eb = b_i[w*DW +: DW];
    step();
    chk("launch_gnt", gnt_o, 1 << w);
    chk("launch_men", m_en_o, 1);
    chk("launch_busy", busy_o, 1);
    chk("launch_ma", m_a_o, ea);
    chk("launch_mb", m_b_o, eb);
    wait_done(n);
    chk("latency", n, exp_err ? TMO : l);
    chk("done", done_o, 1 << w);
    chk("err", err_o, exp_err);
    chk("c", c_o, c);
    chk("men_low", m_en_o, 0);
    step();
    chk("rel_done", done_o, 0);
    chk("rel_gnt", gnt_o, 0);
    chk("rel_busy", busy_o, 0);
    chk("rel_err", err_o, 0);
    chk("rel_c_hold", c_o, c);
    mptr = (w + 1) % NR;
  endtask
  initial begin
    int n, w, last, seen;
    logic [NR-1:0] r;
    tv[0] = '{4'b0100, 3, 64'h0000_0002_8000_0000, 64'hFFFF_FFFE_8000_0000, 64'hFFFF_FFFC_4000_0000, 2};
    tv[1] = '{4'b0011, 1, 64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 0};
    tv[2] = '{4'b0011, 2, 64'h0000_0003_0000_0000, 64'hFFFF_FFFE_0000_0000, 64'hFFFF_FFFA_0000_0000, 1};
    tv[3] = '{4'b0011, 4, 64'h0000_0000_4000_0000, 64'h0000_0000_4000_0000, 64'h0000_0000_1000_0000, 0};
    tv[4] = '{4'b1000, 2, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 3};
    tv[5] = '{4'b1010, 5, 64'h0000_0007_0000_0000, 64'h0000_0000_C000_0000, 64'h0000_0005_4000_0000, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      a_i[tv[i].w*DW +: DW] = tv[i].a;
      b_i[tv[i].w*DW +: DW] = tv[i].b;
      run_op(tv[i].req, tv[i].lat, tv[i].w, tv[i].c, 1'b0);
    end
    do_reset();
    rand_ops();
    lat = 3;
    req_i = 4'b1111;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      wait_done(n);
      chk("rr_order", done_o, 1 << (i % NR));
      chk("rr_c", c_o, mul(a_i[(i % NR)*DW +: DW], b_i[(i % NR)*DW +: DW]));
      if (i > 0) chk("rr_gap", cyc - last, lat + 2);
      last = cyc;
    end
    req_i = '0;
    step();
    mptr = 1;
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      do r = NR'($urandom()); while (r == '0);
      w = pick(r);
      run_op(r, $urandom_range(1, 6), w, mul(a_i[w*DW +: DW], b_i[w*DW +: DW]), 1'b0);
    end
    rand_ops();
    never = 1'b1;
    run_op(4'b0011, 3, pick(4'b0011), '0, 1'b1);
    never = 1'b0;
    w = pick(4'b0011);
    run_op(4'b0011, 2, w, mul(a_i[w*DW +: DW], b_i[w*DW +: DW]), 1'b0);
    a_i[3*DW +: DW] = 64'h0000_0002_8000_0000;
    b_i[3*DW +: DW] = 64'hFFFF_FFFE_8000_0000;
    lat = 4;
    req_i = 4'b1000;
    step();
    chk("chg_gnt", gnt_o, 4'b1000);
    a_i[3*DW +: DW] = 64'h1234_5678_9ABC_DEF0;
    req_i = '0;
    step();
    chk("chg_ma", m_a_o, 64'h0000_0002_8000_0000);
    chk("chg_men", m_en_o, 0);
    wait_done(n);
    chk("chg_done", done_o, 4'b1000);
    chk("chg_c", c_o, 64'hFFFF_FFFC_4000_0000);
    step();
    chk("chg_rel", gnt_o, 0);
    mptr = 0;
    run_op(4'b0010, 2, 1, mul(a_i[1*DW +: DW], b_i[1*DW +: DW]), 1'b0);
    lat = 10;
    req_i = 4'b0100;
    step();
    chk("mid_gnt", gnt_o, 4'b0100);
    step();
    step();
    rstn = 1'b0;
    req_i = '0;
    step();
    chk_zero("mid_rst");
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | int'(done_o) | int'(busy_o) | int'(gnt_o);
    end
    chk("mid_quiet", seen, 0);
    chk("mid_c", c_o, 0);
    mptr = 0;
    rand_ops();
    run_op(4'b0101, 2, pick(4'b0101), mul(a_i[0 +: DW], b_i[0 +: DW]), 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that shares one clocked signed fixed-point multiplier (64-bit, 32.32) between several requesters. Typical requesters are Goertzel filter channels and their magnitude/normalisation stages. The block selects one requester, launches a single multiply with a one-cycle start pulse, and waits for the multiplier's valid. It then returns the product with a per-requester done pulse. A timeout recovers from a multiplier that never responds.

## Interface
- NR, 4, number of requesters (2..16)
- DW, 64, operand/result width (signed 32.32)
- TMO, 64, max cycles to wait for multiplier valid after launch (≥2)

- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- req_i  in  NR  per-requester request level
- a_i  in  NR×DW  per-requester operand A, signed
- b_i  in  NR×DW  per-requester operand B, signed
- gnt_o  out  NR  one-hot grant, held launch→completion
- done_o  out  NR  one-cycle completion pulse to owner
- err_o  out  1  qualifies done_o: 1 = timeout, result invalid
- c_o  out  DW  product of last completed op, held until next completion
- busy_o  out  1  operation in flight
- m_en_o  out  1  multiplier start pulse
- m_a_o  out  DW  multiplier operand A
- m_b_o  out  DW  multiplier operand B
- m_valid_i  in  1  multiplier result valid
- m_c_i  in  DW  multiplier result

## Operation
- State machine has three states: IDLE, WAIT, RELEASE. Reset enters IDLE.
- **IDLE**
  - If any req_i bit is set, the winner is the first set bit searching upward from ptr, wrapping modulo NR.
  - Register gnt_o ← onehot(winner), m_a_o ← a_i[winner], m_b_o ← b_i[winner], m_en_o ← 1, busy_o ← 1, tmo_cnt ← 0. Go to WAIT.
  - If no req_i bit is set, stay in IDLE.
  - m_valid_i is ignored in IDLE.
- **WAIT**
  - m_en_o returns to 0 (exactly one-cycle pulse). m_a_o and m_b_o stay stable.
  - On m_valid_i: c_o ← m_c_i, done_o[owner] ← 1, err_o ← 0. Go to RELEASE.
  - Else, if tmo_cnt == TMO−1: c_o ← 0, done_o[owner] ← 1, err_o ← 1. Go to RELEASE.
  - Else tmo_cnt increments.
- **RELEASE**
  - done_o and err_o return to 0. gnt_o ← 0, busy_o ← 0, ptr ← (owner+1) mod NR. Go to IDLE.
  - c_o keeps its value.
- **Arbitration rules**
  - ptr resets to 0, so requester 0 has initial priority.
  - A requester that keeps req_i high after done gets its next turn only after every other pending requester has been served.
- **Requester contract**
  - Hold req_i and operands until done.
  - Operands are sampled only at the IDLE launch edge. Changes after launch do not affect the running op.
  - Deasserting req_i while granted does not abort the op. done_o still pulses to the owner.
- **Arithmetic:** the block performs none. Widths pass through unchanged, and c_o is the raw m_c_i.
- **Reset mid-operation:** all outputs, ptr and tmo_cnt clear on the next edge. A late m_valid_i afterwards is ignored because the FSM is in IDLE.

## Timing
- Reset values: gnt_o=0, done_o=0, err_o=0, c_o=0, busy_o=0, m_en_o=0, m_a_o=0, m_b_o=0.
- Let req_i be sampled in IDLE at edge T.
  - Edge T: m_en_o and gnt_o registered.
  - Multiplier sees start in cycle T..T+1.
- Let m_valid_i be sampled high at edge T+L, with L ≥ 1.
  - c_o and done_o are registered at edge T+L, visible in the following cycle.
  - Edge T+L+1: RELEASE.
  - Next launch: edge T+L+2 at the earliest.
- Throughput: one op per L+2 cycles.
- Timeout: done_o with err_o=1 is registered at edge T+TMO.
- m_valid_i high in the same cycle as m_en_o counts as a valid response at the first WAIT edge, so L=1 is legal.
- gnt_o is high from edge T through edge T+L+1, and is never high for two requesters.

## Test plan
- **Single op:** NR=4, requester 2 requests with a=0x0000_0002_8000_0000 (2.5), b=0xFFFF_FFFE_8000_0000 (−1.5), multiplier model latency 3.
  - Required: m_en_o is a single pulse, gnt_o=4'b0100, c_o=0xFFFF_FFFC_4000_0000 (−3.75), done_o[2] is a 1-cycle pulse, err_o=0.
- **Round robin:** req_i=4'b1111 held continuously.
  - Required: grants in order 0,1,2,3,0, each completion L+2 cycles apart.
- **Priority after service:** requester 1 is served, then req_i=4'b0011.
  - Required: next grant goes to requester 0 (ptr=2 wraps to 0), not requester 1.
- **Timeout:** multiplier model never asserts valid, TMO=8.
  - Required: done_o[owner] and err_o=1 occur exactly 8 cycles after launch, c_o=0, and the next requester is granted afterwards.
- **Operand change / req drop:** after launch, change a_i and drop req_i of the owner.
  - Required: m_a_o is unchanged, and done_o still pulses with the product of the original operands.
- **Reset mid-op:** assert rstn low during WAIT, release it, then the model asserts m_valid_i.
  - Required: all outputs are 0, no done_o pulses, and the first grant after reset goes to requester 0.
